// File: rtl/mcpu_prog_loader.sv
// Byte-stream program loader for the MCPU. It clears the RAM, then loads
// length-prefixed 16-bit words and releases the CPU once the XOR checksum matches.
module mcpu_prog_loader #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_SIZE = 8,
  parameter int RAM_SIZE  = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 ram_we,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic [WORD_SIZE-1:0] ram_wdata,
  output logic                 cpu_reset,
  output logic                 done,
  output logic                 error
);

  localparam int CW = $clog2(RAM_SIZE + 1);
  localparam logic [CW-1:0] LP_N = CW'(RAM_SIZE);

  typedef enum logic [2:0] {
    S_INIT, S_CLEAR, S_LEN, S_HI, S_LO, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_idx;
  logic [CW-1:0] r_len;
  logic [7:0]    r_hi;
  logic [7:0]    r_csum;
  logic          w_acc;

  always_comb begin
    in_ready  = (r_state == S_LEN) || (r_state == S_HI) ||
                (r_state == S_LO)  || (r_state == S_CSUM);
    cpu_reset = (r_state != S_DONE);
    done      = (r_state == S_DONE);
    error     = (r_state == S_ERR);
    w_acc     = in_valid && in_ready;
  end

  // The word write is registered off the LO byte, so it lands in the cycle
  // where HI/CSUM is already accepting the next byte: no stall between words.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_INIT;
      r_idx     <= '0;
      r_len     <= '0;
      r_hi      <= '0;
      r_csum    <= '0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      ram_we <= 1'b0;
      case (r_state)
        S_INIT: begin
          r_state   <= S_CLEAR;
          ram_we    <= 1'b1;
          ram_addr  <= '0;
          ram_wdata <= '0;
          r_idx     <= CW'(1);
        end
        S_CLEAR: begin
          if (r_idx == LP_N) begin
            r_state <= S_LEN;
            r_idx   <= '0;
          end else begin
            ram_we   <= 1'b1;
            ram_addr <= r_idx[ADDR_SIZE-1:0];
            r_idx    <= r_idx + CW'(1);
          end
        end
        S_LEN: begin
          if (w_acc) begin
            r_len   <= (in_data == 8'h00) ? LP_N : CW'(in_data);
            r_csum  <= in_data;
            r_state <= S_HI;
          end
        end
        S_HI: begin
          if (w_acc) begin
            r_hi    <= in_data;
            r_csum  <= r_csum ^ in_data;
            r_state <= S_LO;
          end
        end
        S_LO: begin
          if (w_acc) begin
            ram_we    <= 1'b1;
            ram_addr  <= r_idx[ADDR_SIZE-1:0];
            ram_wdata <= WORD_SIZE'({r_hi, in_data});
            r_csum    <= r_csum ^ in_data;
            r_idx     <= r_idx + CW'(1);
            r_state   <= (r_idx == r_len - CW'(1)) ? S_CSUM : S_HI;
          end
        end
        S_CSUM: begin
          if (w_acc) begin
            r_state <= (in_data == r_csum) ? S_DONE : S_ERR;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mcpu_prog_loader.sv
// Directed bench for mcpu_prog_loader: a stream-level model predicts every RAM
// write and the final status; a negedge monitor checks the DUT against it.
module tb_mcpu_prog_loader;

  localparam int RS = 256;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        ram_we;
  logic [7:0]  ram_addr;
  logic [15:0] ram_wdata;
  logic        cpu_reset;
  logic        done;
  logic        error;

  mcpu_prog_loader #(
    .WORD_SIZE (16),
    .ADDR_SIZE (8),
    .RAM_SIZE  (RS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .cpu_reset (cpu_reset),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  a;
    logic [15:0] d;
  } wr_t;

  wr_t         exp_q[$];
  logic [7:0]  stream[$];
  logic [15:0] mem_dut[RS];
  logic [7:0]  model_csum;
  int          n_chk = 0;
  int          n_err = 0;
  bit          mon_en = 1'b0;
  bit          ok;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Words are consecutive (hi,lo) byte pairs after the length byte; the
  // checksum byte must equal the XOR of every byte before it.
  function automatic bit model_build();
    int         n;
    logic [7:0] acc;
    logic [7:0] hi;
    logic [7:0] lo;
    n   = (stream[0] == 8'h00) ? RS : int'(stream[0]);
    acc = stream[0];
    for (int w = 0; w < n; w++) begin
      hi = stream[1 + 2*w];
      lo = stream[2 + 2*w];
      exp_q.push_back({8'(w), hi, lo});
      acc = acc ^ hi ^ lo;
    end
    model_csum = acc;
    return stream[1 + 2*n] == acc;
  endfunction

  always @(negedge clk) begin
    wr_t e;
    if (!reset) begin
      chk("rst_outs", 32'({in_ready, ram_we, ram_addr, ram_wdata, cpu_reset, done, error}), 32'd4);
    end else if (mon_en) begin
      chk("cpu_reset_vs_done", 32'(cpu_reset), 32'(!done));
      if (done || error) chk("ready_when_finished", 32'(in_ready), 32'd0);
      if (ram_we) begin
        if (exp_q.size() == 0) begin
          chk("extra_write", 32'(ram_addr), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", 32'(ram_addr), 32'(e.a));
          chk("wr_data", 32'(ram_wdata), 32'(e.d));
        end
        mem_dut[ram_addr] = ram_wdata;
      end
    end
  end

  task automatic wait_ready();
    int k;
    k = 0;
    while (in_ready !== 1'b1 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 1000) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 reset = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    for (int i = 0; i < RS; i++) exp_q.push_back({8'(i), 16'h0000});
    @(posedge clk);
    #2 reset = 1'b1;
    wait_ready();
    chk("clear_writes_seen", 32'(exp_q.size()), 32'd0);
    chk("clear_cpu_reset", 32'(cpu_reset), 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int k;
    if (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    k = 0;
    while (in_ready !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) chk("byte_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic run_load(input bit gap);
    bit exp_ok;
    exp_ok = model_build();
    foreach (stream[i]) send_byte(stream[i], gap);
    @(negedge clk);
    in_valid = 1'b0;
    chk("done", 32'(done), 32'(exp_ok));
    chk("error", 32'(error), 32'(!exp_ok));
    chk("cpu_reset_final", 32'(cpu_reset), 32'(!exp_ok));
    chk("words_written", 32'(exp_q.size()), 32'd0);
    in_valid = 1'b1;
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    chk("status_sticky", 32'({done, error}), 32'({exp_ok, !exp_ok}));
  endtask

  initial begin
    stream = {8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
    ok = model_build();
    chk("model_small_ok", 32'(ok), 32'd1);
    chk("model_w0", 32'(exp_q[0].d), 32'h1234);
    chk("model_w1", 32'(exp_q[1].d), 32'hABCD);
    chk("model_csum", 32'(model_csum), 32'h42);
    exp_q.delete();
    mon_en = 1'b1;

    do_reset();
    run_load(1'b0);
    chk("mem0_small", 32'(mem_dut[0]), 32'h1234);
    chk("mem1_small", 32'(mem_dut[1]), 32'hABCD);
    chk("mem2_cleared", 32'(mem_dut[2]), 32'h0000);

    stream[5] = 8'h43;
    do_reset();
    run_load(1'b0);
    chk("mem0_err", 32'(mem_dut[0]), 32'h1234);
    chk("mem1_err", 32'(mem_dut[1]), 32'hABCD);
    chk("error_lit", 32'(error), 32'd1);

    stream[5] = 8'h42;
    do_reset();
    run_load(1'b1);
    chk("mem0_gap", 32'(mem_dut[0]), 32'h1234);
    chk("mem1_gap", 32'(mem_dut[1]), 32'hABCD);

    stream.delete();
    stream.push_back(8'h00);
    for (int i = 0; i < 512; i++) stream.push_back(8'(i));
    stream.push_back(8'h00);
    ok = model_build();
    chk("model_big_ok", 32'(ok), 32'd1);
    chk("model_big_count", 32'(exp_q.size()), 32'd256);
    chk("model_big_last", 32'(exp_q[255]), 32'hFF_FEFF);
    exp_q.delete();
    do_reset();
    run_load(1'b0);
    chk("mem0_big", 32'(mem_dut[0]), 32'h0001);
    chk("mem255_big", 32'(mem_dut[255]), 32'hFEFF);

    stream = {8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
    do_reset();
    ok = model_build();
    for (int i = 0; i < 3; i++) send_byte(stream[i], 1'b0);
    reset    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("abort_outs", 32'({in_ready, ram_we, ram_addr, ram_wdata, cpu_reset, done, error}), 32'd4);
    repeat (2) @(negedge clk);
    chk("abort_no_write", 32'(mem_dut[0]), 32'h0000);
    do_reset();
    run_load(1'b0);
    chk("mem0_reload", 32'(mem_dut[0]), 32'h1234);
    chk("mem1_reload", 32'(mem_dut[1]), 32'hABCD);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
